// File: rtl/cfg_reg_pkg.sv
// Shared types and helpers for the cfg_reg_bank register target.
package cfg_reg_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} cfg_reg_state_t;

    localparam int WAIT_CNT_W     = 4;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int LOCK_BIT_IDX   = DATA_WIDTH_DEF - 1;

    function automatic logic addr_is_ctrl(input int unsigned addr, input int unsigned num_ctrl);
        return addr < num_ctrl;
    endfunction

    function automatic logic addr_is_stat(input int unsigned addr, input int unsigned num_ctrl,
                                          input int unsigned num_stat);
        return (addr >= num_ctrl) && (addr < num_ctrl + num_stat);
    endfunction

endpackage

// File: rtl/cfg_reg_decode.sv
// Address decode for cfg_reg_bank: classifies the word address and flags
// out-of-range, read-only-write and locked-write errors.
module cfg_reg_decode
    import cfg_reg_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_CTRL   = 4,
    parameter int NUM_STAT   = 2
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  is_wr,
    input  logic                  lock,
    output logic                  hit_ctrl,
    output logic                  hit_stat,
    output logic [ADDR_WIDTH-1:0] ctrl_idx,
    output logic [ADDR_WIDTH-1:0] stat_idx,
    output logic                  err
);

    assign hit_ctrl = addr_is_ctrl(32'(addr), NUM_CTRL);
    assign hit_stat = addr_is_stat(32'(addr), NUM_CTRL, NUM_STAT);
    assign ctrl_idx = addr;
    assign stat_idx = addr - ADDR_WIDTH'(NUM_CTRL);

    // A set lock blocks every control write, including the one that would clear it.
    assign err = !(hit_ctrl || hit_stat) || (is_wr && hit_stat) || (is_wr && hit_ctrl && lock);

endmodule

// File: rtl/cfg_reg_bank.sv
// Control/status register bank behind the APB bridge, with programmable wait states.
// Optional sticky write lock in ctrl[0] MSB when CFG_REG_LOCK_EN is defined.
module cfg_reg_bank
    import cfg_reg_pkg::*;
#(
    parameter int                   ADDR_WIDTH  = 3,
    parameter int                   DATA_WIDTH  = 32,
    parameter int                   NUM_CTRL    = 4,
    parameter int                   NUM_STAT    = 2,
    parameter int                   WAIT_CYCLES = 0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_bus_req,
    input  logic                           i_bus_req_is_wr,
    input  logic [ADDR_WIDTH-1:0]          i_bus_addr,
    input  logic [DATA_WIDTH-1:0]          i_bus_wr_data,
    input  logic [DATA_WIDTH-1:0]          i_bus_wr_biten,
    output logic                           o_bus_req_stall_wr,
    output logic                           o_bus_req_stall_rd,
    output logic                           o_bus_ready,
    output logic [DATA_WIDTH-1:0]          o_bus_rd_data,
    output logic                           o_bus_err,
    output logic [NUM_CTRL*DATA_WIDTH-1:0] o_ctrl,
    input  logic [NUM_STAT*DATA_WIDTH-1:0] i_status
);

    localparam int LOCK_IDX = (DATA_WIDTH == DATA_WIDTH_DEF) ? LOCK_BIT_IDX : DATA_WIDTH - 1;
`ifdef CFG_REG_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    cfg_reg_state_t                     state, state_nxt;
    logic [WAIT_CNT_W-1:0]              cnt, cnt_nxt;
    logic                               is_wr_q;
    logic [ADDR_WIDTH-1:0]              addr_q;
    logic [DATA_WIDTH-1:0]              wr_data_q, wr_biten_q;
    logic                               ready_q, err_q, commit_q;
    logic [DATA_WIDTH-1:0]              rd_data_q, rd_word;
    logic [NUM_CTRL-1:0][DATA_WIDTH-1:0] ctrl;
    logic [NUM_STAT-1:0][DATA_WIDTH-1:0] status;

    logic                  accept, enter_resp, lock;
    logic                  is_wr_eff;
    logic [ADDR_WIDTH-1:0] addr_eff;
    logic                  hit_ctrl, hit_stat, dec_err;
    logic [ADDR_WIDTH-1:0] ctrl_idx, stat_idx;

    assign status = i_status;
    assign o_ctrl = ctrl;
    assign lock   = LOCK_EN && ctrl[0][LOCK_IDX];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (i_bus_req) begin
                if (WAIT_CYCLES == 0) begin
                    state_nxt = RESP;
                end else begin
                    state_nxt = WAIT;
                    cnt_nxt   = WAIT_CNT_W'(WAIT_CYCLES - 1);
                end
            end
            WAIT: if (cnt == '0) state_nxt = RESP;
                  else           cnt_nxt   = cnt - 1'b1;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign accept     = (state == IDLE) && i_bus_req;
    assign enter_resp = (state_nxt == RESP) && (state != RESP);

    // With zero wait states RESP is entered on the accept edge itself, so the
    // response must be decoded from the live request rather than the latch.
    assign is_wr_eff = (state == IDLE) ? i_bus_req_is_wr : is_wr_q;
    assign addr_eff  = (state == IDLE) ? i_bus_addr : addr_q;

    cfg_reg_decode #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .NUM_CTRL  (NUM_CTRL),
        .NUM_STAT  (NUM_STAT)
    ) u_decode (
        .addr    (addr_eff),
        .is_wr   (is_wr_eff),
        .lock    (lock),
        .hit_ctrl(hit_ctrl),
        .hit_stat(hit_stat),
        .ctrl_idx(ctrl_idx),
        .stat_idx(stat_idx),
        .err     (dec_err)
    );

    always_comb begin
        rd_word = '0;
        if (!is_wr_eff && !dec_err) begin
            for (int k = 0; k < NUM_CTRL; k++)
                if (hit_ctrl && ctrl_idx == ADDR_WIDTH'(k)) rd_word = ctrl[k];
            for (int k = 0; k < NUM_STAT; k++)
                if (hit_stat && stat_idx == ADDR_WIDTH'(k)) rd_word = status[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_wr_q    <= 1'b0;
            addr_q     <= '0;
            wr_data_q  <= '0;
            wr_biten_q <= '0;
        end else if (accept) begin
            is_wr_q    <= i_bus_req_is_wr;
            addr_q     <= i_bus_addr;
            wr_data_q  <= i_bus_wr_data;
            wr_biten_q <= i_bus_wr_biten;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            commit_q  <= 1'b0;
            rd_data_q <= '0;
        end else if (enter_resp) begin
            ready_q   <= 1'b1;
            err_q     <= dec_err;
            commit_q  <= is_wr_eff && hit_ctrl && !dec_err;
            rd_data_q <= rd_word;
        end else if (state == RESP) begin
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            commit_q  <= 1'b0;
            rd_data_q <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl <= {NUM_CTRL{RESET_VAL}};
        end else if (state == RESP && commit_q) begin
            for (int k = 0; k < NUM_CTRL; k++)
                if (addr_q == ADDR_WIDTH'(k))
                    ctrl[k] <= (ctrl[k] & ~wr_biten_q) | (wr_data_q & wr_biten_q);
        end
    end

    assign o_bus_req_stall_wr = (state != IDLE);
    assign o_bus_req_stall_rd = (state != IDLE);
    assign o_bus_ready        = ready_q;
    assign o_bus_err          = err_q;
    assign o_bus_rd_data      = rd_data_q;

endmodule

// File: tb/tb_cfg_reg_bank.sv
// Randomized bench for cfg_reg_bank against a transaction-level register model.
module tb_cfg_reg_bank;

    localparam int NC = 4;
    localparam int NS = 2;
    localparam int W  = 3;
`ifdef CFG_REG_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          i_bus_req = 1'b0;
    logic          i_bus_req_is_wr = 1'b0;
    logic [2:0]    i_bus_addr = '0;
    logic [31:0]   i_bus_wr_data = '0;
    logic [31:0]   i_bus_wr_biten = '0;
    logic          o_bus_req_stall_wr, o_bus_req_stall_rd, o_bus_ready, o_bus_err;
    logic [31:0]   o_bus_rd_data;
    logic [127:0]  o_ctrl;
    logic [NS-1:0][31:0] status_in = '0;

    cfg_reg_bank #(
        .ADDR_WIDTH(3), .DATA_WIDTH(32), .NUM_CTRL(NC), .NUM_STAT(NS),
        .WAIT_CYCLES(W), .RESET_VAL('0)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_bus_req         (i_bus_req),
        .i_bus_req_is_wr   (i_bus_req_is_wr),
        .i_bus_addr        (i_bus_addr),
        .i_bus_wr_data     (i_bus_wr_data),
        .i_bus_wr_biten    (i_bus_wr_biten),
        .o_bus_req_stall_wr(o_bus_req_stall_wr),
        .o_bus_req_stall_rd(o_bus_req_stall_rd),
        .o_bus_ready       (o_bus_ready),
        .o_bus_rd_data     (o_bus_rd_data),
        .o_bus_err         (o_bus_err),
        .o_ctrl            (o_ctrl),
        .i_status          (status_in)
    );

    always #5 clk = ~clk;

    // Reference state and per-cycle expectations.
    logic [NC-1:0][31:0] m_ctrl = '0;
    logic        exp_stall = 1'b0, exp_ready = 1'b0, exp_err = 1'b0;
    logic [31:0] exp_rd = '0;
    bit          chk_en = 1'b0;
    int          cyc = 0;

    // Hand-computed pins on specific responses / control words.
    bit          pin_en = 1'b0, pin_err = 1'b0, pin_c_en = 1'b0;
    logic [31:0] pin_rd = '0, pin_c = '0;
    int          pin_c_idx = 0;
    string       pin_name = "";

    int vectors = 0;
    int miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (o_bus_ready !== exp_ready || o_bus_req_stall_wr !== exp_stall ||
                o_bus_req_stall_rd !== exp_stall || o_bus_rd_data !== exp_rd ||
                o_bus_err !== exp_err || o_ctrl !== m_ctrl) begin
                miscompares++;
                $display("FAIL cycle %0d: ready %b want %b stall %b/%b want %b rd %h want %h err %b want %b ctrl %h want %h",
                         cyc, o_bus_ready, exp_ready, o_bus_req_stall_wr, o_bus_req_stall_rd, exp_stall,
                         o_bus_rd_data, exp_rd, o_bus_err, exp_err, o_ctrl, m_ctrl);
            end
            if (pin_en && exp_ready) begin
                vectors++;
                if (o_bus_rd_data !== pin_rd || o_bus_err !== pin_err) begin
                    miscompares++;
                    $display("FAIL pin %s: rd %h want %h err %b want %b", pin_name,
                             o_bus_rd_data, pin_rd, o_bus_err, pin_err);
                end
            end
            if (pin_c_en) begin
                vectors++;
                if (o_ctrl[pin_c_idx*32 +: 32] !== pin_c) begin
                    miscompares++;
                    $display("FAIL pin ctrl[%0d]: got %h want %h", pin_c_idx,
                             o_ctrl[pin_c_idx*32 +: 32], pin_c);
                end
            end
        end
    end

    function automatic void model(input bit wr, input logic [2:0] a, output logic [31:0] rd,
                                  output bit err, output bit commit);
        int ai = int'(a);
        rd = '0; err = 1'b0; commit = 1'b0;
        if (ai >= NC + NS)  err = 1'b1;
        else if (ai >= NC) begin
            if (wr) err = 1'b1;
            else    rd  = status_in[ai - NC];
        end else if (wr) begin
            if (LOCK && m_ctrl[0][31]) err = 1'b1;
            else                       commit = 1'b1;
        end else rd = m_ctrl[ai];
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Called 1ns after a posedge with the DUT idle; returns 1ns after the
    // edge that leaves RESP.
    task automatic txn(input bit wr, input logic [2:0] a, input logic [31:0] d,
                       input logic [31:0] be, input bit hold, input bit pin,
                       input logic [31:0] prd, input bit perr, input string nm);
        logic [31:0] rd;
        bit err, commit;
        i_bus_req = 1'b1; i_bus_req_is_wr = wr; i_bus_addr = a;
        i_bus_wr_data = d; i_bus_wr_biten = be;
        model(wr, a, rd, err, commit);
        @(posedge clk); #1;
        if (!hold) begin
            i_bus_req = 1'b0; i_bus_req_is_wr = ~wr; i_bus_addr = 3'($urandom_range(0, 7));
            i_bus_wr_data = $urandom; i_bus_wr_biten = $urandom;
        end
        repeat (W) begin exp_stall = 1'b1; @(posedge clk); #1; end
        exp_stall = 1'b1; exp_ready = 1'b1; exp_rd = rd; exp_err = err;
        pin_en = pin; pin_rd = prd; pin_err = perr; pin_name = nm;
        @(posedge clk); #1;
        if (commit) m_ctrl[a] = (m_ctrl[a] & ~be) | (d & be);
        exp_stall = 1'b0; exp_ready = 1'b0; exp_rd = '0; exp_err = 1'b0; pin_en = 1'b0;
        i_bus_req = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0; i_bus_req = 1'b0;
        m_ctrl = '0; exp_stall = 1'b0; exp_ready = 1'b0; exp_rd = '0; exp_err = 1'b0; pin_en = 1'b0;
        idle(n);
        rst_n = 1'b1;
        idle(1);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Reset values.
        for (int i = 0; i < NC; i++) txn(1'b0, 3'(i), '0, '0, 1'b0, 1'b1, 32'h0, 1'b0, "reset_rd");

        // Partial-enable write then readback.
        txn(1'b1, 3'd1, 32'hDEADBEEF, 32'h0000FFFF, 1'b0, 1'b1, 32'h0, 1'b0, "wr_partial");
        pin_c_en = 1'b1; pin_c_idx = 1; pin_c = 32'h0000BEEF;
        txn(1'b0, 3'd1, '0, '0, 1'b0, 1'b1, 32'h0000BEEF, 1'b0, "rd_partial");
        pin_c_en = 1'b0;

        // Status read and read-only protection.
        status_in[0] = 32'hA5A5A5A5; status_in[1] = 32'h5A5A0F0F;
        idle(1);
        txn(1'b0, 3'd4, '0, '0, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, "rd_stat0");
        txn(1'b1, 3'd4, 32'h11111111, '1, 1'b0, 1'b1, 32'h0, 1'b1, "wr_stat0");
        txn(1'b0, 3'd4, '0, '0, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, "rd_stat0_again");
        txn(1'b0, 3'd5, '0, '0, 1'b0, 1'b1, 32'h5A5A0F0F, 1'b0, "rd_stat1");

        // Out of range.
        txn(1'b0, 3'd7, '0, '0, 1'b0, 1'b1, 32'h0, 1'b1, "rd_oor");
        txn(1'b1, 3'd6, '1, '1, 1'b0, 1'b1, 32'h0, 1'b1, "wr_oor");

        // Zero enables: completes cleanly, no change.
        txn(1'b1, 3'd1, 32'hFFFFFFFF, '0, 1'b0, 1'b1, 32'h0, 1'b0, "wr_biten0");

        // Back-to-back with the request held throughout.
        txn(1'b1, 3'd2, 32'hCAFEF00D, '1, 1'b1, 1'b0, '0, 1'b0, "");
        txn(1'b0, 3'd2, '0, '0, 1'b1, 1'b1, 32'hCAFEF00D, 1'b0, "b2b_rd");

        // Reset in the middle of a write: aborted, no ready, no commit.
        i_bus_req = 1'b1; i_bus_req_is_wr = 1'b1; i_bus_addr = 3'd3;
        i_bus_wr_data = 32'hFFFFFFFF; i_bus_wr_biten = '1;
        @(posedge clk); #1;
        i_bus_req = 1'b0; exp_stall = 1'b1;
        idle(1);
        do_reset(2);
        idle(W + 2);
        pin_c_en = 1'b1; pin_c_idx = 3; pin_c = 32'h0;
        idle(1);
        pin_c_en = 1'b0;

        // Lock bit behaviour (plain RW bit when the lock feature is off).
        txn(1'b1, 3'd0, 32'h80000001, '1, 1'b0, 1'b1, 32'h0, 1'b0, "lock_set");
        txn(1'b1, 3'd2, 32'h00001234, '1, 1'b0, 1'b1, 32'h0, LOCK, "wr_after_lock");
        txn(1'b0, 3'd0, '0, '0, 1'b0, 1'b1, 32'h80000001, 1'b0, "rd_lock_reg");
        do_reset(2);
        txn(1'b1, 3'd2, 32'h00001234, '1, 1'b0, 1'b1, 32'h0, 1'b0, "wr_after_reset");
        txn(1'b0, 3'd2, '0, '0, 1'b0, 1'b1, 32'h00001234, 1'b0, "rd_after_reset");

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] be;
            case ($urandom_range(0, 3))
                0:       be = '0;
                1:       be = '1;
                default: be = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) begin
                status_in[0] = $urandom; status_in[1] = $urandom;
            end
            if ($urandom_range(0, 39) == 0) do_reset(1);
            txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, be,
                1'($urandom_range(0, 1)), 1'b0, '0, 1'b0, "");
            idle($urandom_range(0, 2));
        end

        idle(2);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
